// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg -- shared types and sizes for the sequential 8-to-3 encoder.
//   state_t : controller states (IDLE, EMIT)
//   N_REQ   : request vector width
//   IDX_W   : encoded index width
//   CNT_W   : pending-count width (must hold 0..N_REQ)
// ---------------------------------------------------------------------------
package enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8t3.sv
// ---------------------------------------------------------------------------
// prio_enc8t3 -- combinational 8-to-3 priority encoder.
//   Parameter MSB_FIRST : 1 = bit 7 wins, 0 = bit 0 wins.
//   vec  in  [7:0]  request vector
//   idx  out [2:0]  index of the winning bit, 0 when vec == 0
//   any  out        at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_enc8t3
    import enc_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan so that the highest-priority set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N_REQ; i++)
                if (vec[i]) idx = IDX_W'(i);
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--)
                if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/seq_encoder8t3.sv
// ---------------------------------------------------------------------------
// seq_encoder8t3 -- captures a multi-hot request vector and emits the index
// of each set bit, one per accepted transfer, in priority order.
//   Parameter MSB_FIRST : 1 = bit 7 highest priority, 0 = bit 0 highest.
//   Macro ENC_MERGE_EN  : when defined, a Load while emitting ORs W into the
//                         pending set; otherwise such a Load is ignored.
//   Clock  in        rising-edge clock
//   Reset  in        asynchronous active-high reset
//   W      in  [7:0] request vector, sampled when Load=1
//   Load   in        capture W
//   Ready  in        consumer accepts the current code
//   Y      out [2:0] index of the highest-priority pending bit
//   Valid  out       Y holds a code awaiting acceptance
//   Zero   out       one-cycle pulse after a Load that captured W=0
//   Count  out [3:0] number of pending bits
// ---------------------------------------------------------------------------
module seq_encoder8t3
    import enc_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N_REQ-1:0] W,
    input  logic             Load,
    input  logic             Ready,
    output logic [IDX_W-1:0] Y,
    output logic             Valid,
    output logic             Zero,
    output logic [CNT_W-1:0] Count
);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] pend, pend_nxt;
    logic             zero_nxt;
    logic             pend_any;

    prio_enc8t3 #(.MSB_FIRST(MSB_FIRST)) u_prio (
        .vec (pend),
        .idx (Y),
        .any (pend_any)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pend  <= '0;
            Zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            Zero  <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        zero_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Load) begin
                    if (W != '0) begin
                        pend_nxt  = W;
                        state_nxt = EMIT;
                    end else begin
                        zero_nxt  = 1'b1;
                    end
                end
            end
            EMIT: begin
                // Serve first, then merge, so a re-requested index survives.
                if (Ready && pend_any)
                    pend_nxt[Y] = 1'b0;
`ifdef ENC_MERGE_EN
                if (Load)
                    pend_nxt = pend_nxt | W;
`endif
                state_nxt = (pend_nxt != '0) ? EMIT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

    assign Valid = (state == EMIT);

    always_comb begin
        Count = '0;
        for (int i = 0; i < N_REQ; i++)
            Count = Count + CNT_W'(pend[i]);
    end

endmodule

// File: tb/tb_seq_encoder8t3.sv
module tb_seq_encoder8t3;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] W;
    logic       Load, Ready;
    logic [2:0] Y1, Y0;
    logic       Valid1, Valid0, Zero1, Zero0;
    logic [3:0] Count1, Count0;

    int checks   = 0;
    int failures = 0;
    int q1[$];      // expected codes, MSB-first instance
    int q0[$];      // expected codes, LSB-first instance

    always #5 Clock = ~Clock;

    seq_encoder8t3 #(.MSB_FIRST(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .W(W), .Load(Load), .Ready(Ready),
        .Y(Y1), .Valid(Valid1), .Zero(Zero1), .Count(Count1)
    );

    seq_encoder8t3 #(.MSB_FIRST(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .W(W), .Load(Load), .Ready(Ready),
        .Y(Y0), .Valid(Valid0), .Zero(Zero0), .Count(Count0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drain both instances with Ready=1, comparing each emitted code
    // against its scoreboard; bounded by a cycle budget.
    task automatic drain(input string tag);
        Ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (Valid1) begin
                if (q1.size() > 0) chk({tag, "_y1"}, 32'(Y1), 32'(q1.pop_front()));
                else               chk({tag, "_extra1"}, 32'(Y1), 32'hFFFF);
            end
            if (Valid0) begin
                if (q0.size() > 0) chk({tag, "_y0"}, 32'(Y0), 32'(q0.pop_front()));
                else               chk({tag, "_extra0"}, 32'(Y0), 32'hFFFF);
            end
            if (!Valid1 && !Valid0) break;
            tick();
        end
        chk({tag, "_left1"}, 32'(q1.size()), 0);
        chk({tag, "_left0"}, 32'(q0.size()), 0);
        chk({tag, "_idle1"}, 32'(Valid1), 0);
        chk({tag, "_idle0"}, 32'(Valid0), 0);
        chk({tag, "_cnt1"},  32'(Count1), 0);
    endtask

    initial begin
        Reset = 1'b1; W = '0; Load = 1'b0; Ready = 1'b0;
        #3;
        chk("rst_valid", 32'(Valid1), 0);
        chk("rst_y",     32'(Y1), 0);
        chk("rst_count", 32'(Count1), 0);
        chk("rst_zero",  32'(Zero1), 0);
        tick();
        Reset = 1'b0;
        tick();

        // Three set bits drained back to back in both priority orders.
        Load = 1'b1; W = 8'b1010_0100; Ready = 1'b1;
        tick();
        Load = 1'b0; W = '0;
        q1 = '{7, 5, 2};
        q0 = '{2, 5, 7};
        for (int i = 0; i < 3; i++) begin
            chk("a4_valid1", 32'(Valid1), 1);
            chk("a4_count1", 32'(Count1), 32'(3 - i));
            chk("a4_y1", 32'(Y1), 32'(q1.pop_front()));
            chk("a4_y0", 32'(Y0), 32'(q0.pop_front()));
            tick();
        end
        chk("a4_done_valid", 32'(Valid1), 0);
        chk("a4_done_count", 32'(Count1), 0);

        // Empty load: single Zero pulse, nothing emitted.
        Ready = 1'b0; Load = 1'b1; W = 8'h00;
        tick();
        Load = 1'b0;
        chk("z_zero",  32'(Zero1), 1);
        chk("z_valid", 32'(Valid1), 0);
        chk("z_count", 32'(Count1), 0);
        tick();
        chk("z_zero_end", 32'(Zero1), 0);
        chk("z_valid_end", 32'(Valid1), 0);

        // Backpressure: code must hold while Ready=0.
        Load = 1'b1; W = 8'h81;
        tick();
        Load = 1'b0; W = '0;
        q1 = '{7, 0};
        q0 = '{0, 7};
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid1", 32'(Valid1), 1);
            chk("bp_y1",     32'(Y1), 32'(q1[0]));
            chk("bp_y0",     32'(Y0), 32'(q0[0]));
            chk("bp_count1", 32'(Count1), 2);
            tick();
        end
        drain("bp");

        // Load arriving in the same cycle the first code is accepted.
        Load = 1'b1; W = 8'h81; Ready = 1'b1;
        tick();
        chk("mg_y1_first", 32'(Y1), 7);
        chk("mg_y0_first", 32'(Y0), 0);
        Load = 1'b1; W = 8'h02;
        tick();
        Load = 1'b0; W = '0;
`ifdef ENC_MERGE_EN
        q1 = '{1, 0};
        q0 = '{1, 7};
`else
        q1 = '{0};
        q0 = '{7};
`endif
        drain("mg");

        // Reset in the middle of a drain discards everything.
        Load = 1'b1; W = 8'hFF; Ready = 1'b1;
        tick();
        Load = 1'b0; W = '0;
        q1 = '{7, 6, 5};
        q0 = '{0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            chk("ff_y1", 32'(Y1), 32'(q1.pop_front()));
            chk("ff_y0", 32'(Y0), 32'(q0.pop_front()));
            tick();
        end
        chk("ff_count_pre", 32'(Count1), 5);
        #2 Reset = 1'b1;
        #1;
        chk("ff_rst_valid1", 32'(Valid1), 0);
        chk("ff_rst_valid0", 32'(Valid0), 0);
        chk("ff_rst_count1", 32'(Count1), 0);
        chk("ff_rst_y1",     32'(Y1), 0);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ff_post_valid1", 32'(Valid1), 0);
            chk("ff_post_valid0", 32'(Valid0), 0);
            chk("ff_post_count1", 32'(Count1), 0);
        end

        // Normal operation resumes after reset.
        Load = 1'b1; W = 8'h10;
        tick();
        Load = 1'b0; W = '0;
        q1 = '{4};
        q0 = '{4};
        chk("post_count1", 32'(Count1), 1);
        drain("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
